// File: rtl/fifo_flags.sv
// ----------------------------------------------------------------------------
// fifo_flags -- synchronous single-clock FIFO with status and error flags.
//
// A DEPTH = 2**INDEX_WIDTH entry circular buffer. The occupancy count is kept
// in a register. full, empty, almost_full and almost_empty are all decoded
// from that registered count. overflow and underflow are sticky error flags.
// clr_err clears them, but a set condition in the same cycle wins.
//
// Configuration macro: FIFO_FWFT_EN
//   undefined : standard mode. rd_data is registered and updates one edge
//               after an accepted read. It holds its value otherwise.
//   defined   : first-word-fall-through. rd_data always shows the head word,
//               or 0 when the FIFO is empty. rd_en pops that word.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   wr_en        in   write request
//   wr_data      in   word to write [DATA_WIDTH]
//   rd_en        in   read/pop request
//   rd_data      out  read word [DATA_WIDTH]
//   full, empty  out  count == DEPTH / count == 0
//   almost_full  out  count >= AFULL_LEVEL
//   almost_empty out  count <= AEMPTY_LEVEL
//   count        out  stored words, 0..DEPTH [INDEX_WIDTH+1]
//   overflow     out  sticky: write attempted while full with no read
//   underflow    out  sticky: read attempted while empty
//   clr_err      in   synchronous clear of overflow/underflow
// ----------------------------------------------------------------------------
module fifo_flags #(
   parameter int DATA_WIDTH   = 8,
   parameter int INDEX_WIDTH  = 5,
   parameter int AFULL_LEVEL  = (1 << INDEX_WIDTH) - 4,
   parameter int AEMPTY_LEVEL = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [DATA_WIDTH-1:0]  wr_data,
   input  logic                   rd_en,
   output logic [DATA_WIDTH-1:0]  rd_data,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [INDEX_WIDTH:0]   count,
   output logic                   overflow,
   output logic                   underflow,
   input  logic                   clr_err
);

   localparam int DEPTH = 1 << INDEX_WIDTH;
   localparam logic [INDEX_WIDTH:0] DEPTH_CNT  = DEPTH[INDEX_WIDTH:0];
   localparam logic [INDEX_WIDTH:0] AFULL_CNT  = AFULL_LEVEL[INDEX_WIDTH:0];
   localparam logic [INDEX_WIDTH:0] AEMPTY_CNT = AEMPTY_LEVEL[INDEX_WIDTH:0];

   logic [DATA_WIDTH-1:0]  mem [DEPTH];

   logic [INDEX_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [INDEX_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [INDEX_WIDTH:0]   count_q, count_d;
   logic                   overflow_q, overflow_d;
   logic                   underflow_q, underflow_d;
   logic                   rd_ok, wr_ok;
`ifndef FIFO_FWFT_EN
   logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
`endif

   // Every flag is decoded from the registered count. None of them looks at
   // the inputs of the current cycle.
   assign full         = (count_q == DEPTH_CNT);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AFULL_CNT);
   assign almost_empty = (count_q <= AEMPTY_CNT);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first. A path that
      // leaves a variable unassigned would infer a latch.
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      // A full FIFO still accepts a write when a read frees a slot in the
      // same cycle. An empty FIFO never accepts a read, even with a write
      // arriving, because the incoming word is not stored yet.
      rd_ok = rd_en && !empty;
      wr_ok = wr_en && (!full || rd_ok);

      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;

      unique case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Set conditions take priority over clr_err.
      overflow_d  = (wr_en && full && !rd_ok) || (overflow_q  && !clr_err);
      underflow_d = (rd_en && empty)          || (underflow_q && !clr_err);

`ifndef FIFO_FWFT_EN
      rd_data_d = rd_data_q;
      // The read uses the head word as it is before this edge's write. That
      // is correct when full with a read and a write together, where both
      // pointers address the same slot.
      if (rd_ok) rd_data_d = mem[rd_ptr_q];
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only, so that
   // every flop samples the values from before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
`ifndef FIFO_FWFT_EN
         rd_data_q   <= '0;
`endif
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
`ifndef FIFO_FWFT_EN
         rd_data_q   <= rd_data_d;
`endif
      end
   end

   // NOTE: the storage array is deliberately not reset. Reset clears the
   // pointers and the count, so any stale word is unreachable. Leaving the
   // array out of reset lets it map onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_ok && !rst) mem[wr_ptr_q] <= wr_data;
   end

`ifdef FIFO_FWFT_EN
   assign rd_data = empty ? '0 : mem[rd_ptr_q];
`else
   assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_fifo_flags.sv
// ----------------------------------------------------------------------------
// tb_fifo_flags -- directed self-checking bench for fifo_flags.
// It builds in standard mode by default, and in FWFT mode when FIFO_FWFT_EN
// is defined. The step task returns the word a pop delivered in both modes,
// so the data checks can be written once for either mode.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_flags;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en, rd_en, clr_err;
   logic [7:0] wr_data, rd_data;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;
   logic [5:0] count;
   logic [7:0] popped;

   int n_cmp = 0;
   int n_err = 0;

   fifo_flags dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow),
      .clr_err      (clr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Runs one clock cycle with the given requests, then samples 1 ns after
   // the edge. popped receives the word a read delivers. In FWFT mode that
   // word is visible before the edge. In standard mode it appears after it.
   task automatic step(input logic w, input logic [7:0] wd, input logic r);
      logic [7:0] pre;
      wr_en   = w;
      wr_data = wd;
      rd_en   = r;
      pre     = rd_data;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
`ifdef FIFO_FWFT_EN
      popped = pre;
`else
      popped = rd_data;
`endif
   endtask

   task automatic clear_errors();
      clr_err = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      clr_err = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_aempty", almost_empty, 1);
      check("rst_full", full, 0);
      check("rst_afull", almost_full, 0);
      check("rst_ovf", overflow, 0);
      check("rst_unf", underflow, 0);
      check("rst_rdata", rd_data, 0);
      rst = 1'b0;

      // Fill with 0x01..0x20. almost_full goes high at count 28.
      for (int i = 1; i <= 32; i++) begin
         step(1'b1, 8'(i), 1'b0);
         check("fill_count", count, i);
         check("fill_afull", almost_full, (i >= 28) ? 1 : 0);
      end
      check("fill_full", full, 1);
      step(1'b1, 8'hEE, 1'b0);
      check("ovf_set", overflow, 1);
      check("ovf_count", count, 32);
      check("ovf_unf", underflow, 0);
      clear_errors();
      check("ovf_clr", overflow, 0);
      clr_err = 1'b1;
      step(1'b1, 8'hEE, 1'b0);
      clr_err = 1'b0;
      check("ovf_set_beats_clr", overflow, 1);
      clear_errors();
      check("ovf_clr2", overflow, 0);

      // Drain. Data must come out in order. almost_empty goes high at
      // count 4.
      for (int i = 1; i <= 32; i++) begin
         step(1'b0, 8'h00, 1'b1);
         check("drain_data", popped, i);
         check("drain_count", count, 32 - i);
         check("drain_aempty", almost_empty, ((32 - i) <= 4) ? 1 : 0);
      end
      check("drain_empty", empty, 1);
      step(1'b0, 8'h00, 1'b1);
      check("unf_set", underflow, 1);
      check("unf_count", count, 0);
      clear_errors();
      check("unf_clr", underflow, 0);

      // Full FIFO with simultaneous read and write: count holds, no overflow.
      for (int i = 1; i <= 32; i++) step(1'b1, 8'(i), 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 8'(8'hA0 + i), 1'b1);
         check("pass_data", popped, i + 1);
         check("pass_count", count, 32);
      end
      check("pass_ovf", overflow, 0);
      for (int i = 0; i < 32; i++) begin
         step(1'b0, 8'h00, 1'b1);
         check("pass_drain", popped, (i < 22) ? (8'h0B + i) : (8'hA0 + i - 22));
      end
      check("pass_empty", empty, 1);

      // Stream 100 words at a level of 16. The pointers wrap three times.
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
      for (int i = 16; i < 100; i++) begin
         step(1'b1, 8'(i), 1'b1);
         check("stream_data", popped, i - 16);
      end
      check("stream_count", count, 16);
      for (int i = 84; i < 100; i++) begin
         step(1'b0, 8'h00, 1'b1);
         check("stream_tail", popped, i);
      end
      check("stream_empty", empty, 1);

      // Empty FIFO with read and write: the write is taken, the read is
      // refused and underflow sets.
      step(1'b1, 8'h77, 1'b1);
      check("erw_unf", underflow, 1);
      check("erw_count", count, 1);
      step(1'b0, 8'h00, 1'b1);
      check("erw_data", popped, 8'h77);
      clear_errors();

      // Asynchronous reset in mid-cycle after five writes.
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_count", count, 0);
      check("arst_empty", empty, 1);
      check("arst_aempty", almost_empty, 1);
      check("arst_rdata", rd_data, 0);
      wr_en = 1'b1; wr_data = 8'h99;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      check("arst_wr_ignored", count, 0);
      rst = 1'b0;
      step(1'b1, 8'h55, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      check("arst_first", popped, 8'h55);

      // A single word in an empty FIFO: shows the read latency of the mode.
      step(1'b1, 8'h3C, 1'b0);
`ifdef FIFO_FWFT_EN
      check("lat_pre", rd_data, 8'h3C);
`else
      check("lat_pre", rd_data, 8'h55);
`endif
      step(1'b0, 8'h00, 1'b1);
      check("lat_post", popped, 8'h3C);
      check("lat_empty", empty, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_flags.md
FIFO_FLAGS -- requirements
Module: fifo_flags

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each stored word in bits.
REQ-002 Parameter INDEX_WIDTH, default 5: pointer width; depth DEPTH = 1<<INDEX_WIDTH (32).
REQ-003 Parameter AFULL_LEVEL, default DEPTH-4 (28): count at or above which almost_full asserts.
REQ-004 Parameter AEMPTY_LEVEL, default 4: count at or below which almost_empty asserts.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_data  input  DATA_WIDTH  word to write.
REQ-009 rd_en  input  1  read/pop request.
REQ-010 rd_data  output  DATA_WIDTH  read word.
REQ-011 full / empty  output  1 each  count==DEPTH / count==0.
REQ-012 almost_full / almost_empty  output  1 each  threshold flags.
REQ-013 count  output  INDEX_WIDTH+1  number of stored words, 0..DEPTH.
REQ-014 overflow / underflow  output  1 each  sticky error flags.
REQ-015 clr_err  input  1  synchronous clear of both sticky error flags.

Function
REQ-016 Storage SHALL be a DEPTH-entry circular buffer with INDEX_WIDTH-bit write/read pointers that wrap from DEPTH-1 to 0.
REQ-017 Read accepted = rd_en && !empty; write accepted = wr_en && (!full || read accepted).
REQ-018 Accepted write SHALL store wr_data at wr_ptr and advance wr_ptr; accepted read SHALL advance rd_ptr.
REQ-019 count SHALL increment on write-only, decrement on read-only, and hold when both or neither are accepted; all flags SHALL derive from registered count.
REQ-020 Full with wr_en and rd_en: both accepted, count stays DEPTH, no overflow.
REQ-021 Empty with wr_en and rd_en: write accepted, read rejected, underflow sets, count becomes 1.
REQ-022 overflow SHALL set on wr_en while full with no read accepted; underflow SHALL set on rd_en while empty; rejected operations SHALL not alter pointers, count or memory.
REQ-023 clr_err SHALL clear both flags next edge; a same-cycle set condition SHALL win over clr_err.
REQ-024 almost_full = (count >= AFULL_LEVEL); almost_empty = (count <= AEMPTY_LEVEL).
REQ-025 Pointer wrap SHALL be invisible at the interface: data order is strict FIFO across any number of wraps.

Reset
REQ-026 rst high SHALL asynchronously force pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rd_data=0.
REQ-027 Memory contents need not be reset; reset mid-operation discards all stored words, and the first word written after release is the first read.
REQ-028 While rst is high, wr_en and rd_en SHALL be ignored.

Configuration
REQ-029 Macro FIFO_FWFT_EN undefined (standard mode): on accepted read, rd_data SHALL update at the next edge with the head word (1-cycle latency) and otherwise hold its last value.
REQ-030 FIFO_FWFT_EN defined (first-word-fall-through): rd_data SHALL continuously present mem[rd_ptr] when !empty (0 when empty), a word visible the cycle after its write; rd_en pops it.
REQ-031 All other requirements SHALL hold identically in both modes.

Verification
REQ-032 Reset, then write 0x01..0x20 (32 words) -> full=1, count=32, almost_full from count=28; 33rd write -> overflow=1, count stays 32.
REQ-033 Drain 32 reads -> data 0x01..0x20 in order, empty=1 after last, almost_empty from count=4; 33rd read -> underflow=1.
REQ-034 Full FIFO, wr_en=rd_en=1 for 10 cycles writing 0xA0.. -> count stays 32, no overflow, reads return oldest words in order.
REQ-035 Stream 100 words (0x00..0x63) at count~16 with simultaneous read/write -> output order matches, across 3+ pointer wraps.
REQ-036 Write 5 words, assert rst mid-cycle asynchronously -> outputs reach reset values before next edge; write 0x55 then read -> 0x55.
REQ-037 Both modes: single write 0x3C into empty FIFO -> FWFT: rd_data=0x3C before rd_en; standard: rd_data=0x3C the cycle after rd_en.
